// File: rtl/sender_pkg.sv
// Shared definitions for the serial pattern sender and its BCD frame counter.
//   state_t    : sender FSM state encoding
//   IDLE_LEVEL : level driven on the serial data line between frames
//   BCD_MAX    : largest value of a single BCD digit
package sender_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic       IDLE_LEVEL = 1'b1;
  localparam logic [3:0] BCD_MAX    = 4'd9;

endpackage

// File: rtl/bcd_counter_4.sv
// Four-digit BCD event counter, 0000..9999, wrapping back to 0000.
//   clk_i            : system clock
//   rst_i            : asynchronous active-low reset, clears all digits
//   inc_i            : count one event on this clock edge
//   digit0_o..3_o    : BCD units, tens, hundreds, thousands
module bcd_counter_4
  import sender_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  output logic [3:0] digit0_o,
  output logic [3:0] digit1_o,
  output logic [3:0] digit2_o,
  output logic [3:0] digit3_o
);

  // Each digit rolls over to zero and carries into the next one only when
  // every lower digit is at 9; the thousands digit simply wraps.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      digit0_o <= 4'd0;
      digit1_o <= 4'd0;
      digit2_o <= 4'd0;
      digit3_o <= 4'd0;
    end else if (inc_i) begin
      if (digit0_o != BCD_MAX) begin
        digit0_o <= digit0_o + 4'd1;
      end else begin
        digit0_o <= 4'd0;
        if (digit1_o != BCD_MAX) begin
          digit1_o <= digit1_o + 4'd1;
        end else begin
          digit1_o <= 4'd0;
          if (digit2_o != BCD_MAX) begin
            digit2_o <= digit2_o + 4'd1;
          end else begin
            digit2_o <= 4'd0;
            digit3_o <= (digit3_o != BCD_MAX) ? digit3_o + 4'd1 : 4'd0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/serial_pattern_sender.sv
// Serial pattern sender: shifts a latched WIDTH-bit pattern out MSB first on
// data_o with a set_o strobe per bit (setup / strobe / hold phases of
// TICK_DIV cycles each) and counts completed frames in BCD.
//   clk_i, rst_i      : clock, asynchronous active-low reset
//   start_i           : frame request, honoured only in IDLE
//   pattern_i         : frame data, latched when start_i is accepted
//   repeat_i          : at end of frame, 1 = resend without returning to IDLE
//   data_o, set_o     : serial bit and its strobe
//   busy_o, done_o    : frame in progress, one-cycle end-of-frame pulse
//   count0_o..3_o     : BCD count of completed frames
//
// state  | meaning
// IDLE   | line parked at IDLE_LEVEL, waiting for start_i
// SETUP  | current bit driven, strobe low (setup margin)
// STROBE | strobe high, bit held
// HOLD   | strobe low, bit held (hold margin); advance bit or end frame
module serial_pattern_sender
  import sender_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 50000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic             repeat_i,
  output logic             data_o,
  output logic             set_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [3:0]       count0_o,
  output logic [3:0]       count1_o,
  output logic [3:0]       count2_o,
  output logic [3:0]       count3_o
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(WIDTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic             data_d, set_d, busy_d, done_d;
  logic             phase_end;
  logic             frame_end;

  assign phase_end = (timer_q == TIMER_LAST);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    pat_d     = pat_q;
    frame_end = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SETUP;
          pat_d   = pattern_i;
          idx_d   = '0;
        end
      end
      SETUP:  if (phase_end) state_d = STROBE;
      STROBE: if (phase_end) state_d = HOLD;
      HOLD: begin
        if (phase_end) begin
          if (idx_q != IDX_LAST) begin
            state_d = SETUP;
            idx_d   = idx_q + 1'b1;
          end else begin
            frame_end = 1'b1;
            idx_d     = '0;
            state_d   = repeat_i ? SETUP : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The timer only runs in the timed phases and is back at 0 on every
    // phase boundary, so it is already 0 whenever IDLE is left.
    if (state_q != IDLE) begin
      timer_d = phase_end ? '0 : timer_q + 1'b1;
    end

    // Outputs are decoded from the next state so they register in the same
    // cycle the state does; the bit only changes on SETUP entry because
    // idx_d/pat_d only change there.
    data_d = (state_d == IDLE) ? IDLE_LEVEL : pat_d[IDX_LAST - idx_d];
    set_d  = (state_d == STROBE);
    busy_d = (state_d != IDLE);
    done_d = frame_end;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      pat_q   <= '0;
      data_o  <= IDLE_LEVEL;
      set_o   <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      data_o  <= data_d;
      set_o   <= set_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
    end
  end

  bcd_counter_4 u_frame_count (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc_i    (frame_end),
    .digit0_o (count0_o),
    .digit1_o (count1_o),
    .digit2_o (count2_o),
    .digit3_o (count3_o)
  );

endmodule

// File: tb/tb_serial_pattern_sender.sv
module tb_serial_pattern_sender;

  localparam int W  = 8;
  localparam int TD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         start_i = 1'b0;
  logic [W-1:0] pattern_i = '0;
  logic         repeat_i = 1'b0;
  logic         data_o, set_o, busy_o, done_o;
  logic [3:0]   c0, c1, c2, c3;

  logic         s_start = 1'b0;
  logic [1:0]   s_pattern = '0;
  logic         s_repeat = 1'b0;
  logic         s_data, s_set, s_busy, s_done;
  logic [3:0]   s_c0, s_c1, s_c2, s_c3;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  serial_pattern_sender #(.WIDTH(W), .TICK_DIV(TD)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_i), .pattern_i(pattern_i),
    .repeat_i(repeat_i), .data_o(data_o), .set_o(set_o), .busy_o(busy_o),
    .done_o(done_o), .count0_o(c0), .count1_o(c1), .count2_o(c2), .count3_o(c3)
  );

  serial_pattern_sender #(.WIDTH(2), .TICK_DIV(1)) u_small (
    .clk_i(clk), .rst_i(rst_n), .start_i(s_start), .pattern_i(s_pattern),
    .repeat_i(s_repeat), .data_o(s_data), .set_o(s_set), .busy_o(s_busy),
    .done_o(s_done), .count0_o(s_c0), .count1_o(s_c1), .count2_o(s_c2), .count3_o(s_c3)
  );

  // data_o must hold while set_o is high and for TD cycles after it falls.
  logic mon_en = 1'b0;
  logic prev_data = 1'b1;
  int   hold_left = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (set_o || hold_left > 0) begin
        n_compared++;
        if (data_o !== prev_data) begin
          n_mismatched++;
          $display("FAIL data_stable: data_o=%b required %b (set_o=%b) at %0t", data_o, prev_data, set_o, $time);
        end
      end
      if (set_o) hold_left = TD;
      else if (hold_left > 0) hold_left--;
    end else begin
      hold_left = 0;
    end
    prev_data = data_o;
  end

  // Loopback 01011 sequence detector, clocked by the rising edge of set_o.
  logic       det_clear = 1'b0;
  logic       det_prev_set = 1'b0;
  logic [4:0] det_hist = '0;
  int         det_count = 0;
  always @(negedge clk) begin
    if (det_clear) begin
      det_hist = '0;
      det_count = 0;
      det_prev_set = 1'b0;
    end else begin
      if (set_o && !det_prev_set) begin
        det_hist = {det_hist[3:0], data_o};
        if (det_hist == 5'b01011) det_count++;
      end
      det_prev_set = set_o;
    end
  end

  task automatic apply_reset();
    mon_en = 1'b0;
    start_i = 1'b0; repeat_i = 1'b0; s_start = 1'b0; s_repeat = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_compared++; if (data_o !== 1'b1) begin n_mismatched++; $display("FAIL reset_data: got %b required 1", data_o); end
    n_compared++; if (set_o !== 1'b0) begin n_mismatched++; $display("FAIL reset_set: got %b required 0", set_o); end
    n_compared++; if (busy_o !== 1'b0) begin n_mismatched++; $display("FAIL reset_busy: got %b required 0", busy_o); end
    n_compared++; if (done_o !== 1'b0) begin n_mismatched++; $display("FAIL reset_done: got %b required 0", done_o); end
    n_compared++; if ({c3, c2, c1, c0} !== 16'h0000) begin n_mismatched++; $display("FAIL reset_count: got %h required 0000", {c3, c2, c1, c0}); end
    n_compared++; if (s_data !== 1'b1) begin n_mismatched++; $display("FAIL reset_small_data: got %b required 1", s_data); end
    n_compared++; if (s_busy !== 1'b0) begin n_mismatched++; $display("FAIL reset_small_busy: got %b required 0", s_busy); end
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_basic_frame();
    logic [7:0] pat;
    logic exp_d, exp_s, exp_b, exp_dn;
    pat = 8'b0101_1000;
    apply_reset();
    pattern_i = pat; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (t < 48) begin
        exp_d = pat[7 - t / 6]; exp_s = ((t % 6) / 2 == 1); exp_b = 1'b1; exp_dn = 1'b0;
      end else begin
        exp_d = 1'b1; exp_s = 1'b0; exp_b = 1'b0; exp_dn = (t == 48);
      end
      n_compared++; if (data_o !== exp_d) begin n_mismatched++; $display("FAIL basic_data t=%0d: got %b required %b", t, data_o, exp_d); end
      n_compared++; if (set_o !== exp_s) begin n_mismatched++; $display("FAIL basic_set t=%0d: got %b required %b", t, set_o, exp_s); end
      n_compared++; if (busy_o !== exp_b) begin n_mismatched++; $display("FAIL basic_busy t=%0d: got %b required %b", t, busy_o, exp_b); end
      n_compared++; if (done_o !== exp_dn) begin n_mismatched++; $display("FAIL basic_done t=%0d: got %b required %b", t, done_o, exp_dn); end
      if (t == 48) begin
        n_compared++; if ({c3, c2, c1, c0} !== 16'h0001) begin n_mismatched++; $display("FAIL basic_count: got %h required 0001", {c3, c2, c1, c0}); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_repeat_loopback();
    int ndone;
    apply_reset();
    det_clear = 1'b1;
    @(negedge clk);
    det_clear = 1'b0;
    pattern_i = 8'b0101_1000; repeat_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    ndone = 0;
    for (int t = 0; t < 200 && ndone < 3; t++) begin
      if (done_o) begin
        ndone++;
        n_compared++; if (t != 48 * ndone) begin n_mismatched++; $display("FAIL repeat_done_time #%0d: got t=%0d required %0d", ndone, t, 48 * ndone); end
        n_compared++; if (busy_o !== (ndone < 3)) begin n_mismatched++; $display("FAIL repeat_busy #%0d: got %b required %b", ndone, busy_o, ndone < 3); end
        if (ndone == 2) repeat_i = 1'b0;
      end
      @(negedge clk);
    end
    n_compared++; if (ndone != 3) begin n_mismatched++; $display("FAIL repeat_frames: got %0d required 3", ndone); end
    n_compared++; if (det_count != 3) begin n_mismatched++; $display("FAIL repeat_detector: got %0d required 3", det_count); end
    n_compared++; if ({c3, c2, c1, c0} !== 16'h0003) begin n_mismatched++; $display("FAIL repeat_count: got %h required 0003", {c3, c2, c1, c0}); end
  endtask

  task automatic test_ignore_start();
    logic [7:0] pat;
    logic exp_d, exp_s, exp_dn;
    pat = 8'b1010_0101;
    apply_reset();
    pattern_i = pat; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (t == 10 || t == 30) begin start_i = 1'b1; pattern_i = 8'b0101_1010; end
      else start_i = 1'b0;
      exp_d  = (t < 48) ? pat[7 - t / 6] : 1'b1;
      exp_s  = (t < 48) && ((t % 6) / 2 == 1);
      exp_dn = (t == 48);
      n_compared++; if (data_o !== exp_d) begin n_mismatched++; $display("FAIL ignore_data t=%0d: got %b required %b", t, data_o, exp_d); end
      n_compared++; if (set_o !== exp_s) begin n_mismatched++; $display("FAIL ignore_set t=%0d: got %b required %b", t, set_o, exp_s); end
      n_compared++; if (done_o !== exp_dn) begin n_mismatched++; $display("FAIL ignore_done t=%0d: got %b required %b", t, done_o, exp_dn); end
      @(negedge clk);
    end
    n_compared++; if (busy_o !== 1'b0) begin n_mismatched++; $display("FAIL ignore_busy: got %b required 0", busy_o); end
    n_compared++; if ({c3, c2, c1, c0} !== 16'h0001) begin n_mismatched++; $display("FAIL ignore_count: got %h required 0001", {c3, c2, c1, c0}); end
  endtask

  // Runs straight after test_ignore_start so the count is 0001 going in.
  task automatic test_reset_midframe();
    logic [7:0] pat;
    logic exp_d, exp_s;
    pattern_i = 8'b1000_0011; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (8) @(negedge clk);
    n_compared++; if (set_o !== 1'b1 || data_o !== 1'b0) begin n_mismatched++; $display("FAIL midreset_pre: set=%b data=%b required 1 0", set_o, data_o); end
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_compared++; if (set_o !== 1'b0) begin n_mismatched++; $display("FAIL midreset_set: got %b required 0", set_o); end
    n_compared++; if (data_o !== 1'b1) begin n_mismatched++; $display("FAIL midreset_data: got %b required 1", data_o); end
    n_compared++; if (busy_o !== 1'b0) begin n_mismatched++; $display("FAIL midreset_busy: got %b required 0", busy_o); end
    n_compared++; if ({c3, c2, c1, c0} !== 16'h0000) begin n_mismatched++; $display("FAIL midreset_count: got %h required 0000", {c3, c2, c1, c0}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    pat = 8'b1000_0001;
    pattern_i = pat; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int t = 0; t < 49; t++) begin
      exp_d = (t < 48) ? pat[7 - t / 6] : 1'b1;
      exp_s = (t < 48) && ((t % 6) / 2 == 1);
      n_compared++; if (data_o !== exp_d) begin n_mismatched++; $display("FAIL postreset_data t=%0d: got %b required %b", t, data_o, exp_d); end
      n_compared++; if (set_o !== exp_s) begin n_mismatched++; $display("FAIL postreset_set t=%0d: got %b required %b", t, set_o, exp_s); end
      if (t == 48) begin
        n_compared++; if (done_o !== 1'b1) begin n_mismatched++; $display("FAIL postreset_done: got %b required 1", done_o); end
        n_compared++; if ({c3, c2, c1, c0} !== 16'h0001) begin n_mismatched++; $display("FAIL postreset_count: got %h required 0001", {c3, c2, c1, c0}); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_bcd_wrap();
    int frames;
    logic [15:0] exp_cnt;
    logic chk, exp_d, exp_s, exp_dn;
    apply_reset();
    s_pattern = 2'b10; s_repeat = 1'b1; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    frames = 0;
    for (int t = 0; t < 61000 && frames < 10000; t++) begin
      if (t < 7) begin
        exp_d  = (t < 3 || t == 6);
        exp_s  = (t == 1 || t == 4);
        exp_dn = (t == 6);
        n_compared++; if (s_data !== exp_d) begin n_mismatched++; $display("FAIL tick1_data t=%0d: got %b required %b", t, s_data, exp_d); end
        n_compared++; if (s_set !== exp_s) begin n_mismatched++; $display("FAIL tick1_set t=%0d: got %b required %b", t, s_set, exp_s); end
        n_compared++; if (s_done !== exp_dn) begin n_mismatched++; $display("FAIL tick1_done t=%0d: got %b required %b", t, s_done, exp_dn); end
      end
      if (s_done) begin
        frames++;
        chk = 1'b1;
        case (frames)
          9:       exp_cnt = 16'h0009;
          10:      exp_cnt = 16'h0010;
          99:      exp_cnt = 16'h0099;
          100:     exp_cnt = 16'h0100;
          999:     exp_cnt = 16'h0999;
          1000:    exp_cnt = 16'h1000;
          9999:    exp_cnt = 16'h9999;
          10000:   exp_cnt = 16'h0000;
          default: begin chk = 1'b0; exp_cnt = 16'h0000; end
        endcase
        if (chk) begin
          n_compared++;
          if ({s_c3, s_c2, s_c1, s_c0} !== exp_cnt) begin
            n_mismatched++;
            $display("FAIL bcd_count frame %0d: got %h required %h", frames, {s_c3, s_c2, s_c1, s_c0}, exp_cnt);
          end
        end
        if (frames == 9999) s_repeat = 1'b0;
        if (frames == 10000) begin
          n_compared++; if (s_busy !== 1'b0) begin n_mismatched++; $display("FAIL bcd_final_busy: got %b required 0", s_busy); end
        end
      end
      @(negedge clk);
    end
    n_compared++; if (frames != 10000) begin n_mismatched++; $display("FAIL bcd_frames: got %0d required 10000", frames); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_repeat_loopback();
    test_ignore_start();
    test_reset_midframe();
    test_bcd_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
